// File: rtl/l2_cache_pkg.sv
// Shared FSM state type and address-field helpers for the N-way L2 cache.
package l2_cache_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } l2_state_e;

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                   input int s_offset, input int s_index);
        return addr >> (s_offset + s_index);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                     input int s_offset, input int s_index);
        return (addr >> s_offset) & ((ADDR_W'(1) << s_index) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/l2_plru.sv
// Tree pseudo-LRU state per set: num_ways-1 node bits, heap-ordered, 0 = victim on the left.
module l2_plru #(
    parameter int num_ways = 4,
    parameter int num_sets = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(num_sets)-1:0] set_i,
    input  logic                        access_i,
    input  logic [$clog2(num_ways)-1:0] way_i,
    output logic [$clog2(num_ways)-1:0] victim_o
);

    localparam int WAY_W = $clog2(num_ways);

    logic [num_ways-2:0] tree_q [num_sets];
    logic [num_ways-2:0] tree_d;
    logic [num_ways-2:0] bits;
    int                  vnode;
    int                  unode;
    logic                vdir;
    logic                udir;

    assign bits = tree_q[set_i];

    always_comb begin
        victim_o = '0;
        vnode    = 0;
        vdir     = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            vdir = 1'b0;
            for (int n = 0; n < num_ways - 1; n++) begin
                if (n == vnode) vdir = bits[n];
            end
            victim_o[WAY_W-1-l] = vdir;
            vnode = 2 * vnode + 1 + int'(vdir);
        end
    end

    // Every node on the accessed way's path is turned to point at the other subtree.
    always_comb begin
        tree_d = bits;
        unode  = 0;
        udir   = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            udir = way_i[WAY_W-1-l];
            for (int n = 0; n < num_ways - 1; n++) begin
                if (n == unode) tree_d[n] = ~udir;
            end
            unode = 2 * unode + 1 + int'(udir);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < num_sets; s++) tree_q[s] <= '0;
        end else if (access_i) begin
            tree_q[set_i] <= tree_d;
        end
    end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with tree PLRU replacement.
// Optional perf counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_nway
    import l2_cache_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * 2**s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [s_line-1:0] mem_wdata,
    output logic [s_line-1:0] mem_rdata,
    output logic              mem_resp,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    output logic [31:0]       pmem_address,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int num_sets = 2**s_index;
    localparam int WAY_W    = $clog2(num_ways);

    l2_state_e state_q, state_d;

    logic [s_line-1:0]   data_q  [num_sets][num_ways];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];

    logic [s_tag-1:0]    req_tag;
    logic [s_index-1:0]  req_idx;
    logic [num_ways-1:0] hit_vec;
    logic                hit;
    logic                any_inv;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    victim_sel;
    logic [WAY_W-1:0]    victim_q;
    logic                victim_dirty;
    logic                check_hit;

    assign req_tag = s_tag'(addr_tag(mem_address, s_offset, s_index));
    assign req_idx = s_index'(addr_index(mem_address, s_offset, s_index));

    // Descending scan leaves the lowest-indexed invalid way selected.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = 0; w < num_ways; w++) begin
            hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[req_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit          = |hit_vec;
    assign check_hit    = (state_q == CHECK) && hit;
    assign victim_sel   = any_inv ? inv_way : plru_victim;
    assign victim_dirty = valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel];

    l2_plru #(
        .num_ways (num_ways),
        .num_sets (num_sets)
    ) u_plru (
        .clk      (clk),
        .rst      (rst),
        .set_i    (req_idx),
        .access_i (check_hit),
        .way_i    (hit_way),
        .victim_o (plru_victim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CHECK && !hit) victim_q <= victim_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (mem_read || mem_write) state_d = CHECK;
            CHECK: begin
                if (hit)               state_d = IDLE;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = FILL;
            end
            WRITEBACK: if (pmem_resp) state_d = FILL;
            FILL:      if (pmem_resp) state_d = CHECK;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        pmem_address = '0;
        case (state_q)
            CHECK: begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = data_q[req_idx][hit_way];
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_wdata   = data_q[req_idx][victim_q];
                pmem_address = {tag_q[req_idx][victim_q], req_idx, {s_offset{1'b0}}};
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {s_offset{1'b0}}};
            end
            default: ;
        endcase
    end

    // Tag and line storage carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (state_q == FILL && pmem_resp) begin
            data_q[req_idx][victim_q] <= pmem_rdata;
            tag_q[req_idx][victim_q]  <= req_tag;
        end else if (check_hit && mem_write) begin
            data_q[req_idx][hit_way] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (state_q == FILL && pmem_resp) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end else if (state_q == WRITEBACK && pmem_resp) begin
                dirty_q[req_idx][victim_q] <= 1'b0;
            end else if (check_hit && mem_write) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
        end
    end

`ifdef L2_PERF_CNT_EN
    logic        first_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // A CHECK entered straight from IDLE is the request's first lookup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            first_q <= (state_q == IDLE);
            if (check_hit && first_q)        hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (state_q == CHECK && !hit)    miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway (4 ways, 16 sets, 256-bit lines) with a scripted adaptor.
module tb_l2_cache_nway;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read, mem_write;
    logic [31:0]   mem_address;
    logic [LW-1:0] mem_wdata, mem_rdata;
    logic          mem_resp;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          pmem_read, pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [31:0]   pmem_address;
    logic [31:0]   hit_count, miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    l2_cache_nway dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_address (pmem_address),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request, plays the adaptor (3-cycle responses), checks traffic, data and latency.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [LW-1:0] wdata, input logic exp_wb, input logic [31:0] wb_addr,
                        input logic [LW-1:0] wb_data, input logic exp_fill,
                        input logic [LW-1:0] fill_data, input logic [LW-1:0] exp_rdata,
                        input int exp_lat);
        int   n     = 0;
        int   pcnt  = 0;
        logic saw_wb   = 1'b0;
        logic saw_fill = 1'b0;
        logic done     = 1'b0;
        mem_address = addr;
        mem_wdata   = wdata;
        mem_write   = wr;
        mem_read    = ~wr;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pcnt      = 0;
            end else if (pmem_write || pmem_read) begin
                pcnt++;
                if (pcnt == 1) begin
                    if (pmem_write) begin
                        saw_wb = 1'b1;
                        chk({tag, "/wb_addr"}, LW'(pmem_address), LW'(wb_addr));
                        chk({tag, "/wb_data"}, pmem_wdata, wb_data);
                    end else begin
                        saw_fill = 1'b1;
                        chk({tag, "/fill_addr"}, LW'(pmem_address), LW'({addr[31:5], 5'b0}));
                        chk({tag, "/wb_before_fill"}, LW'(saw_wb), LW'(exp_wb));
                    end
                end
                if (pcnt == 3) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = fill_data;
                end
            end
            if (mem_resp) begin
                done = 1'b1;
                if (!wr) chk({tag, "/rdata"}, mem_rdata, exp_rdata);
                if (exp_lat != 0) chk({tag, "/latency"}, LW'(n), LW'(exp_lat));
            end
        end
        chk({tag, "/resp_seen"}, LW'(done), LW'(1'b1));
        chk({tag, "/wb_seen"}, LW'(saw_wb), LW'(exp_wb));
        chk({tag, "/fill_seen"}, LW'(saw_fill), LW'(exp_fill));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
    endtask

    task automatic rd_hit(input string tag, input logic [31:0] addr, input logic [LW-1:0] exp);
        xact(tag, 1'b0, addr, '0, 1'b0, 32'h0, '0, 1'b0, '0, exp, 2);
    endtask

    task automatic rd_miss(input string tag, input logic [31:0] addr, input logic [LW-1:0] fill);
        xact(tag, 1'b0, addr, '0, 1'b0, 32'h0, '0, 1'b1, fill, fill, 6);
    endtask

    logic [LW-1:0] A5, P1234, W2, F2, F4, F6, F8, FA, F6B, FB, FC, FD, F10;

    initial begin
        A5  = {8{32'hA5A5_A5A5}};
        P1234 = {16{16'h1234}};
        W2  = {8{32'hDEAD_0240}};
        F2  = {8{32'h0F0F_0F0F}};
        F4  = {8{32'h4444_0440}};
        F6  = {8{32'h6666_0640}};
        F8  = {8{32'h8888_0840}};
        FA  = {8{32'hAAAA_0240}};
        F6B = {8{32'h6B6B_0640}};
        FB  = {8{32'hBBBB_0840}};
        FC  = {8{32'hCCCC_0240}};
        FD  = {8{32'hDDDD_0640}};
        F10 = {8{32'h1010_1040}};
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/mem_resp", LW'(mem_resp), '0);
        chk("reset/pmem_read", LW'(pmem_read), '0);
        chk("reset/pmem_write", LW'(pmem_write), '0);
        chk("reset/pmem_address", LW'(pmem_address), '0);
        chk("reset/mem_rdata", mem_rdata, '0);
        chk("reset/hit_count", LW'(hit_count), '0);
        chk("reset/miss_count", LW'(miss_count), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        rd_miss("cold_rd_40", 32'h0000_0040, A5);
        rd_hit("rpt_rd_40", 32'h0000_0040, A5);
        xact("wr_hit_40", 1'b1, 32'h40, P1234, 1'b0, 32'h0, '0, 1'b0, '0, '0, 2);
        rd_hit("rd_after_wr_40", 32'h0000_0040, P1234);

        // Write miss allocates way 1; the merge makes it dirty with W2.
        xact("wr_miss_240", 1'b1, 32'h240, W2, 1'b0, 32'h0, '0, 1'b1, F2, '0, 6);
        rd_miss("rd_440", 32'h0000_0440, F4);
        rd_miss("rd_640", 32'h0000_0640, F6);
        rd_hit("touch_040", 32'h0000_0040, P1234);
        rd_hit("touch_440", 32'h0000_0440, F4);

        // Tree now points at way 1 (0x240, dirty): writeback then fill.
        xact("evict_240", 1'b0, 32'h840, '0, 1'b1, 32'h240, W2, 1'b1, F8, F8, 10);
        // Next victim is way 3 (0x640, clean).
        xact("evict_640", 1'b0, 32'h240, '0, 1'b0, 32'h0, '0, 1'b1, FA, FA, 6);
        // Next victim is way 0 (0x040, dirty with the 0x1234 pattern).
        xact("evict_040", 1'b0, 32'h640, '0, 1'b1, 32'h040, P1234, 1'b1, F6B, F6B, 10);
        rd_hit("rd_840", 32'h0000_0840, F8);

        // Async reset while a fill is outstanding.
        mem_address = 32'h0000_1040;
        mem_read    = 1'b1;
        pmem_rdata  = F10;
        for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
        chk("rst/fill_started", LW'(pmem_read), LW'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        chk("rst/pmem_read", LW'(pmem_read), '0);
        chk("rst/pmem_write", LW'(pmem_write), '0);
        chk("rst/mem_resp", LW'(mem_resp), '0);
        chk("rst/pmem_address", LW'(pmem_address), '0);
        chk("rst/hit_count", LW'(hit_count), '0);
        chk("rst/miss_count", LW'(miss_count), '0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        rd_miss("post_rst_840", 32'h0000_0840, FB);
        rd_miss("post_rst_240", 32'h0000_0240, FC);
        rd_miss("post_rst_640", 32'h0000_0640, FD);
        rd_hit("cnt_hit1", 32'h0000_0840, FB);
        rd_hit("cnt_hit2", 32'h0000_0240, FC);
        rd_hit("cnt_hit3", 32'h0000_0640, FD);
        rd_hit("cnt_hit4", 32'h0000_0840, FB);
        rd_hit("cnt_hit5", 32'h0000_0240, FC);
`ifdef L2_PERF_CNT_EN
        chk("perf/miss_count", LW'(miss_count), LW'(32'd3));
        chk("perf/hit_count", LW'(hit_count), LW'(32'd5));
`else
        chk("perf/miss_count", LW'(miss_count), '0);
        chk("perf/hit_count", LW'(hit_count), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 cache between the arbiter (line-granular requests) and the cacheline adaptor.
- Generalises the fixed 2-way/LRU-bit L2 to configurable associativity and set count with tree pseudo-LRU replacement.
- Tags, valid, dirty and PLRU state live in flop arrays, so lookup is combinational from the registered request.

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes
s_index, 4, set-index bits; num_sets = 2**s_index
num_ways, 4, associativity; power of two, 2..8
s_tag, 32-s_offset-s_index, tag width (derived)
s_line, 8*2**s_offset, line width in bits (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mem_read  in  1  line read request; held until mem_resp
mem_write  in  1  line write request; held until mem_resp
mem_address  in  32  request address; low s_offset bits ignored
mem_wdata  in  s_line  full-line write data
mem_rdata  out  s_line  read data; valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_rdata  in  s_line  fill data from adaptor
pmem_resp  in  1  adaptor completion
pmem_read  out  1  fill request; held until pmem_resp
pmem_write  out  1  writeback request; held until pmem_resp
pmem_wdata  out  s_line  victim line
pmem_address  out  32  line-aligned address, low s_offset bits zero
hit_count  out  32  perf counter (see Optional Feature)
miss_count  out  32  perf counter

Behaviour:
- FSM: IDLE, CHECK, WRITEBACK, FILL.
- Reset (rst=0, async): state=IDLE; all valid, dirty and PLRU bits cleared; tags and data not reset. mem_resp, pmem_read and pmem_write=0 immediately; mem_rdata, pmem_wdata and pmem_address=0; counters=0. An in-flight pmem transaction is abandoned.
- IDLE: mem_read|mem_write -> CHECK. The request is not re-latched; requester holds address, data and command until mem_resp.
- CHECK: hit = valid[w] && tag[w]==addr tag, for any way w.
  - Hit: mem_resp=1 this cycle; mem_rdata = line of the hit way.
  - Write hit: line <= mem_wdata, dirty <= 1 at clock edge.
  - Any hit: PLRU updated to point away from the hit way; -> IDLE.
  - Hit latency is 2 cycles from request assertion to mem_resp.
- Miss victim selection: lowest-indexed invalid way; otherwise the PLRU victim. Victim valid && dirty -> WRITEBACK, else -> FILL.
- Victim is latched on entry to WRITEBACK/FILL and is stable until FILL completes.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line. On pmem_resp -> FILL; dirty cleared.
- FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp: victim line <= pmem_rdata, tag written, valid=1, dirty=0; -> CHECK, which then hits.
  - The write data merge happens on that hit, never during FILL.
- mem_read and mem_write both high: treated as write.
- pmem_resp outside WRITEBACK/FILL is ignored.
- mem_resp never asserts outside CHECK.
- PLRU is a tree of num_ways-1 bits per set. Each access sets every node on the path to point at the other subtree. Victim is found by following node bits from the root (0=left).
- Miss latency, clean: 2 + fill cycles + 1. Dirty: adds the writeback cycles.

Optional Feature:
- L2_PERF_CNT_EN defined:
  - hit_count increments once per request that hits on its first CHECK visit.
  - miss_count increments once per request that enters WRITEBACK or FILL.
  - Counters are 32-bit and wrap at 2**32 without saturation.
- Undefined: hit_count and miss_count tied to 0; no counter flops.

Decomposition:
- l2_cache_pkg:
  - state enum (IDLE, CHECK, WRITEBACK, FILL)
  - line-width and address-field helper constants
  - function deriving tag/index from an address
- Sub-module l2_plru, parametrised by num_ways and num_sets:
  - inputs: set index, access valid, accessed way
  - output: victim way for the indexed set
  - owns the PLRU bit array and its reset

Test Plan:
- Cold read 0x0000_0040, 4 ways -> pmem_read with pmem_address 0x40; after pmem_resp returning 0xA5..A5, mem_resp with mem_rdata 0xA5..A5.
- Repeat read 0x40 -> mem_resp exactly 2 cycles after request; no pmem activity.
- Write 0x40 with 0x1234 pattern, then read 0x40 -> same data returned; no pmem_write.
- Fill all 4 ways of set 2 (0x040, 0x240, 0x440, 0x640); touch 0x040, 0x440; read 0x840 -> PLRU victim is the way holding 0x240 or 0x640 per tree state.
  - If the victim is dirty: pmem_write at the victim address precedes pmem_read at 0x840.
- Pull rst low during FILL with pmem_read=1 -> pmem_read drops at once. After rst high, reading the prior hit address misses.
- With L2_PERF_CNT_EN, 3 misses then 5 hits -> miss_count=3, hit_count=5. Without the macro, both read 0.
